// File: rtl/reset_sequencer.sv
// Converts power-on, watchdog and button requests into 68K RESET/HALT hold pulses.
// Defining WDRST_COUNT_EN adds WD_COUNT, a saturating count of accepted watchdog requests.
module reset_sequencer #(
    parameter int unsigned POR_CYCLES      = 1024,
    parameter int unsigned WD_CYCLES       = 16,
    parameter int unsigned BTN_CYCLES      = 64,
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned CNT_W           = 11
) (
    input  logic       CLK_68KCLK,
    input  logic       nRST,
    input  logic       nWDRESET,
    input  logic       nRESET_OUT_68K,
    input  logic       nBTN,
    output logic       nRESET,
    output logic       nHALT,
    output logic       nPERIPH_RST,
    output logic [1:0] RST_CAUSE,
    output logic       RST_BUSY
`ifdef WDRST_COUNT_EN
    ,
    output logic [7:0] WD_COUNT
`endif
);

    typedef enum logic {
        ST_ASSERT = 1'b0,
        ST_RUN    = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'b00,
        CAUSE_WD  = 2'b01,
        CAUSE_BTN = 2'b10
    } cause_e;

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] POR_LEN = CNT_W'(POR_CYCLES);
    localparam logic [CNT_W-1:0] WD_LEN  = CNT_W'(WD_CYCLES);
    localparam logic [CNT_W-1:0] BTN_LEN = CNT_W'(BTN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       wd_sync_q, wd_sync_d;
    logic [1:0]       btn_sync_q, btn_sync_d;
    logic [1:0]       r68_sync_q, r68_sync_d;
    logic             wd_prev_q, wd_prev_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             db_armed_q, db_armed_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cause_e           cause_q, cause_d;
    logic             nreset_q, nreset_d;
    logic             nperiph_q, nperiph_d;
    logic             busy_q, busy_d;

    logic             wd_req;
    logic             btn_req;
    logic             db_active;
    logic [CNT_W-1:0] req_len;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        wd_sync_d  = {wd_sync_q[0], nWDRESET};
        btn_sync_d = {btn_sync_q[0], nBTN};
        r68_sync_d = {r68_sync_q[0], nRESET_OUT_68K};
        wd_prev_d  = wd_sync_q[1];

        // Edge, not level: the watchdog keeps its line low long after expiry.
        wd_req = wd_prev_q & ~wd_sync_q[1];

        // Armed: counting low samples toward a press. Disarmed: counting high samples to re-arm.
        db_active  = db_armed_q ? ~btn_sync_q[1] : btn_sync_q[1];
        db_cnt_d   = '0;
        db_armed_d = db_armed_q;
        btn_req    = 1'b0;
        if (db_active) begin
            if (db_cnt_q == DB_LAST) begin
                db_armed_d = ~db_armed_q;
                btn_req    = db_armed_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        req_len = btn_req ? BTN_LEN : WD_LEN;
        cause_d = cause_q;
        if (btn_req) begin
            cause_d = CAUSE_BTN;
        end else if (wd_req) begin
            cause_d = CAUSE_WD;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ASSERT: begin
                // A new request only ever lengthens the hold still to run.
                if ((btn_req || wd_req) && (req_len > cnt_q)) begin
                    cnt_d = req_len;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RUN: begin
                if (btn_req || wd_req) begin
                    state_d = ST_ASSERT;
                    cnt_d   = req_len;
                end
            end
            default: state_d = ST_ASSERT;
        endcase

        nreset_d  = (state_d == ST_RUN);
        busy_d    = (state_d == ST_ASSERT);
        nperiph_d = (state_d == ST_RUN) ? r68_sync_q[1] : 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK_68KCLK or negedge nRST) begin
        if (!nRST) begin
            wd_sync_q  <= 2'b11;
            btn_sync_q <= 2'b11;
            r68_sync_q <= 2'b11;
            wd_prev_q  <= 1'b1;
            db_cnt_q   <= '0;
            db_armed_q <= 1'b1;
            state_q    <= ST_ASSERT;
            cnt_q      <= POR_LEN;
            cause_q    <= CAUSE_POR;
            nreset_q   <= 1'b0;
            nperiph_q  <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            wd_sync_q  <= wd_sync_d;
            btn_sync_q <= btn_sync_d;
            r68_sync_q <= r68_sync_d;
            wd_prev_q  <= wd_prev_d;
            db_cnt_q   <= db_cnt_d;
            db_armed_q <= db_armed_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            nreset_q   <= nreset_d;
            nperiph_q  <= nperiph_d;
            busy_q     <= busy_d;
        end
    end

    assign nRESET      = nreset_q;
    assign nHALT       = nreset_q;
    assign nPERIPH_RST = nperiph_q;
    assign RST_CAUSE   = cause_q;
    assign RST_BUSY    = busy_q;

`ifdef WDRST_COUNT_EN
    logic [7:0] wd_count_q, wd_count_d;

    always_comb begin
        wd_count_d = wd_count_q;
        if (wd_req && (wd_count_q != 8'hFF)) begin
            wd_count_d = wd_count_q + 8'd1;
        end
    end

    always_ff @(posedge CLK_68KCLK or negedge nRST) begin
        if (!nRST) begin
            wd_count_q <= 8'd0;
        end else begin
            wd_count_q <= wd_count_d;
        end
    end

    assign WD_COUNT = wd_count_q;
`endif

endmodule
